// File: rtl/flow_ctrl_fsm.sv
// Flow-control controller: threshold latch/validation, IDLE/ACTIVE tracking, per-channel pop counters.
// Optional clear-on-read of counters: define CONTADOR_CLR_ON_READ_EN.
module flow_ctrl_fsm #(
  parameter  int NUM_CH     = 8,
  parameter  int FIFO_DEPTH = 8,
  parameter  int CNT_W      = 5,
  localparam int TH_W       = $clog2(FIFO_DEPTH),
  localparam int IDX_W      = $clog2(NUM_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [TH_W-1:0]  alto,
  input  logic [TH_W-1:0]  bajo,
  input  logic [NUM_CH-1:0] empty_fifos,
  input  logic [NUM_CH-1:0] pop_valid,
  input  logic             req,
  input  logic [IDX_W-1:0] idx,
  output logic [TH_W-1:0]  alto_out,
  output logic [TH_W-1:0]  bajo_out,
  output logic             idle_out,
  output logic             active_out,
  output logic             error_out,
  output logic             valid_contador,
  output logic [CNT_W-1:0] contador_out
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [TH_W-1:0]  alto_q, bajo_q;
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  logic             valid_q;
  logic [CNT_W-1:0] rd_q;

  logic all_empty, cnt_en, rd_accept, idx_ok;

  assign all_empty = &empty_fifos;
  assign cnt_en    = (state_q == S_IDLE) || (state_q == S_ACTIVE);
  assign rd_accept = (state_q == S_IDLE) && req;
  assign idx_ok    = int'(idx) < NUM_CH;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  // init wins over empty-flag transitions; ERROR is left only through reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_INIT;
      S_INIT: begin
        if (!init) begin
          if (bajo_q >= alto_q) state_d = S_ERROR;
          else if (all_empty)   state_d = S_IDLE;
          else                  state_d = S_ACTIVE;
        end
      end
      S_IDLE: begin
        if (init)            state_d = S_INIT;
        else if (!all_empty) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (init)           state_d = S_INIT;
        else if (all_empty) state_d = S_IDLE;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    idle_out   = 1'b0;
    active_out = 1'b0;
    error_out  = 1'b0;
    case (state_q)
      S_IDLE:   idle_out   = 1'b1;
      S_ACTIVE: active_out = 1'b1;
      S_ERROR:  error_out  = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alto_q <= '0;
      bajo_q <= '0;
    end else if (state_q == S_INIT && init) begin
      alto_q <= alto;
      bajo_q <= bajo;
    end
  end

  assign alto_out = alto_q;
  assign bajo_out = bajo_q;

  // Counters clear while in RESET and on the edge that enters INIT
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_RESET || (state_d == S_INIT && state_q != S_INIT)) begin
      for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cnt_en && pop_valid[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
`ifdef CONTADOR_CLR_ON_READ_EN
      if (rd_accept && idx_ok) cnt_d[idx] = pop_valid[idx] ? CNT_W'(1) : '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Read returns the pre-increment value; out-of-range index reads as zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      valid_q <= rd_accept;
      if (rd_accept) rd_q <= idx_ok ? cnt_q[idx] : '0;
    end
  end

  assign valid_contador = valid_q;
  assign contador_out   = rd_q;

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// Self-checking bench for flow_ctrl_fsm: directed scenarios plus randomized traffic vs a cycle model.
module tb_flow_ctrl_fsm;

  localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3, M_ERROR = 4;

  logic       clk, reset, init, req;
  logic [2:0] alto, bajo, idx;
  logic [7:0] empty_fifos, pop_valid;
  logic [2:0] alto_out, bajo_out;
  logic       idle_out, active_out, error_out, valid_contador;
  logic [4:0] contador_out;
  logic [14:0] act_vec;

  int n_chk, n_pass;
  int m_mode, m_alto, m_bajo, m_valid, m_rd;
  int m_cnt [8];

  flow_ctrl_fsm #(.NUM_CH(8), .FIFO_DEPTH(8), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .init(init), .alto(alto), .bajo(bajo),
    .empty_fifos(empty_fifos), .pop_valid(pop_valid), .req(req), .idx(idx),
    .alto_out(alto_out), .bajo_out(bajo_out), .idle_out(idle_out),
    .active_out(active_out), .error_out(error_out),
    .valid_contador(valid_contador), .contador_out(contador_out)
  );

  assign act_vec = {alto_out, bajo_out, idle_out, active_out, error_out, valid_contador, contador_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] exp_vec();
    return {3'(m_alto), 3'(m_bajo), m_mode == M_IDLE, m_mode == M_ACTIVE,
            m_mode == M_ERROR, 1'(m_valid), 5'(m_rd)};
  endfunction

  task automatic model_reset();
    m_mode = M_RESET; m_alto = 0; m_bajo = 0; m_valid = 0; m_rd = 0;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
  endtask

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic step();
    int n_mode;
    int n_cnt [8];
    bit acc;
    n_mode = m_mode;
    n_cnt  = m_cnt;
    acc    = (m_mode == M_IDLE) && req;
    case (m_mode)
      M_RESET:  n_mode = M_INIT;
      M_INIT:   if (!init) n_mode = (m_bajo >= m_alto) ? M_ERROR :
                                    (empty_fifos == 8'hFF) ? M_IDLE : M_ACTIVE;
      M_IDLE:   if (init) n_mode = M_INIT; else if (empty_fifos != 8'hFF) n_mode = M_ACTIVE;
      M_ACTIVE: if (init) n_mode = M_INIT; else if (empty_fifos == 8'hFF) n_mode = M_IDLE;
      default:  ;
    endcase
    if (m_mode == M_IDLE || m_mode == M_ACTIVE)
      for (int i = 0; i < 8; i++) if (pop_valid[i]) n_cnt[i] = (m_cnt[i] + 1) % 32;
`ifdef CONTADOR_CLR_ON_READ_EN
    if (acc) n_cnt[idx] = pop_valid[idx] ? 1 : 0;
`endif
    if (m_mode == M_RESET || (n_mode == M_INIT && m_mode != M_INIT))
      for (int i = 0; i < 8; i++) n_cnt[i] = 0;
    if (acc) begin
      m_valid = 1;
      m_rd = (int'(idx) < 8) ? m_cnt[idx] : 0;
    end else begin
      m_valid = 0;
    end
    if (m_mode == M_INIT && init) begin
      m_alto = int'(alto);
      m_bajo = int'(bajo);
    end
    m_mode = n_mode;
    m_cnt  = n_cnt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    init = 0; empty_fifos = 8'hFF; pop_valid = 0; req = 0; idx = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic load(input logic [2:0] a, input logic [2:0] b);
    init = 1; alto = a; bajo = b;
    step();
    step();
    init = 0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #3;
    n_chk++;
    if (act_vec !== 15'd0) $display("FAIL reset_values got %h want %h", act_vec, 15'd0);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    n_chk++;
    if (act_vec !== exp_vec()) $display("FAIL reset_to_init got %h want %h", act_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_load_idle();
    do_reset();
    idle_inputs();
    load(3'd6, 3'd2);
    n_chk++;
    if ({alto_out, bajo_out, idle_out, error_out} !== {3'd6, 3'd2, 1'b1, 1'b0})
      $display("FAIL load_idle got alto=%0d bajo=%0d idle=%b err=%b want 6 2 1 0",
               alto_out, bajo_out, idle_out, error_out);
    else n_pass++;
  endtask

  task automatic test_error();
    do_reset();
    idle_inputs();
    load(3'd2, 3'd5);
    n_chk++;
    if ({error_out, idle_out, active_out} !== 3'b100)
      $display("FAIL error_entry got err=%b idle=%b act=%b want 1 0 0", error_out, idle_out, active_out);
    else n_pass++;
    for (int c = 0; c < 20; c++) begin
      init = 1'($urandom); alto = 3'($urandom); bajo = 3'($urandom);
      pop_valid = 8'($urandom); req = 1'($urandom); idx = 3'($urandom);
      empty_fifos = 8'($urandom);
      step();
      n_chk++;
      if (act_vec !== exp_vec() || error_out !== 1'b1)
        $display("FAIL error_sticky cyc=%0d got %h want %h", c, act_vec, exp_vec());
      else n_pass++;
    end
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #2;
    n_chk++;
    if (act_vec !== 15'd0) $display("FAIL error_reset got %h want %h", act_vec, 15'd0);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_idle_active();
    do_reset();
    idle_inputs();
    load(3'd6, 3'd2);
    empty_fifos = 8'hFB;
    step();
    n_chk++;
    if ({idle_out, active_out} !== 2'b01) $display("FAIL to_active got %b want 01", {idle_out, active_out});
    else n_pass++;
    empty_fifos = 8'hFF;
    step();
    n_chk++;
    if ({idle_out, active_out} !== 2'b10) $display("FAIL to_idle got %b want 10", {idle_out, active_out});
    else n_pass++;
    pop_valid = 8'hFF;
    step(); step(); step();
    pop_valid = 8'h00;
    empty_fifos = 8'hFB;
    step();
    init = 1;
    step();
    n_chk++;
    if ({idle_out, active_out, error_out} !== 3'b000 || act_vec !== exp_vec())
      $display("FAIL active_to_init got %h want %h", act_vec, exp_vec());
    else n_pass++;
    init = 0; empty_fifos = 8'hFF;
    step();
    for (int i = 0; i < 8; i++) begin
      req = 1; idx = 3'(i);
      step();
      n_chk++;
      if ({valid_contador, contador_out} !== {1'b1, 5'd0})
        $display("FAIL cnt_cleared idx=%0d got v=%b c=%0d want v=1 c=0", i, valid_contador, contador_out);
      else n_pass++;
    end
    req = 0;
    step();
  endtask

  task automatic test_wrap();
    empty_fifos = 8'hFB;
    step();
    pop_valid = 8'h08;
    for (int c = 0; c < 33; c++) begin
      req = (c == 10);
      idx = 3'd3;
      step();
      if (c == 10) begin
        n_chk++;
        if (valid_contador !== 1'b0) $display("FAIL req_in_active got v=%b want 0", valid_contador);
        else n_pass++;
      end
    end
    pop_valid = 0; req = 0; empty_fifos = 8'hFF;
    step();
    req = 1; idx = 3'd3;
    step();
    n_chk++;
    if ({valid_contador, contador_out} !== {1'b1, 5'd1})
      $display("FAIL wrap_read got v=%b c=%0d want v=1 c=1", valid_contador, contador_out);
    else n_pass++;
    req = 0;
    step();
    n_chk++;
    if ({valid_contador, contador_out} !== {1'b0, 5'd1})
      $display("FAIL read_pulse_hold got v=%b c=%0d want v=0 c=1", valid_contador, contador_out);
    else n_pass++;
  endtask

  task automatic test_same_edge();
    logic [4:0] second;
`ifdef CONTADOR_CLR_ON_READ_EN
    second = 5'd1;
`else
    second = 5'd5;
`endif
    do_reset();
    idle_inputs();
    load(3'd6, 3'd2);
    pop_valid = 8'h20;
    step(); step(); step(); step();
    req = 1; idx = 3'd5;
    step();
    n_chk++;
    if ({valid_contador, contador_out} !== {1'b1, 5'd4})
      $display("FAIL same_edge_read got v=%b c=%0d want v=1 c=4", valid_contador, contador_out);
    else n_pass++;
    pop_valid = 0;
    step();
    n_chk++;
    if ({valid_contador, contador_out} !== {1'b1, second})
      $display("FAIL second_read got v=%b c=%0d want v=1 c=%0d", valid_contador, contador_out, second);
    else n_pass++;
    req = 0;
  endtask

  task automatic test_async_reset();
    pop_valid = 8'h20;
    step(); step();
    pop_valid = 0; req = 1; idx = 3'd5;
    step();
    n_chk++;
    if (act_vec !== exp_vec() || valid_contador !== 1'b1 || contador_out === 5'd0)
      $display("FAIL pre_async_read got %h want %h", act_vec, exp_vec());
    else n_pass++;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_chk++;
    if ({valid_contador, contador_out, alto_out, bajo_out, idle_out} !== 15'd0)
      $display("FAIL async_reset got v=%b c=%0d alto=%0d bajo=%0d idle=%b want all 0",
               valid_contador, contador_out, alto_out, bajo_out, idle_out);
    else n_pass++;
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int s = 0; s < 4; s++) begin
      logic [2:0] a, b;
      do_reset();
      idle_inputs();
      a = 3'($urandom_range(2, 7));
      b = ($urandom % 5 == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, int'(a) - 1));
      load(a, b);
      for (int c = 0; c < 150; c++) begin
        init        = ($urandom % 40 == 0);
        alto        = 3'($urandom);
        bajo        = 3'($urandom);
        empty_fifos = ($urandom % 3 == 0) ? 8'($urandom) : 8'hFF;
        pop_valid   = 8'($urandom);
        req         = 1'($urandom);
        idx         = 3'($urandom);
        step();
        n_chk++;
        if (act_vec !== exp_vec())
          $display("FAIL random s=%0d cyc=%0d got %h want %h", s, c, act_vec, exp_vec());
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b1;
    alto = 0; bajo = 0;
    idle_inputs();
    model_reset();
    test_reset();
    test_load_idle();
    test_error();
    test_idle_active();
    test_wrap();
    test_same_edge();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
